stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_ctrl_debouncer.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 97 +++++++++
 tb/tb_stopwatch_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
// No logic; compile-time definitions only.
// Imported by the control FSM and its bench.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int ELAPSED_W         = 14;
   localparam int MAX_COUNT_DEFAULT = 9999;

endpackage

// File: rtl/stopwatch_ctrl_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, debounced level, press pulse.
// Latency: a stable raw change reaches the level 2+DEBOUNCE_CYCLES edges later; press is registered.
// No backpressure: press is a single-cycle pulse on the rising edge of the debounced level.
module debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic          level;
   logic [CW-1:0] cnt;

   // Bring the raw asynchronous button into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
      end
   end

   // Count consecutive cycles the synchronized input differs from the level; adopt it
   // once it has held long enough. The counter resets on acceptance, so it never passes
   // CNT_LAST and cannot wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt >= CNT_LAST) begin
            cnt   <= '0;
            level <= sync_b;
            press <= sync_b;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller driven by two debounced pushbuttons.
// Latency: start_watch/clear_watch are registered, one edge after the press pulse.
// No backpressure: presses are single-cycle events; ignored presses are dropped.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int MAX_COUNT       = MAX_COUNT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_start,
   input  logic                 btn_clear,
   input  logic [ELAPSED_W-1:0] elapsed_time,
   output logic                 start_watch,
   output logic                 clear_watch,
   output logic [1:0]           state
);

   localparam logic [ELAPSED_W-1:0] MAX_CMP = ELAPSED_W'(MAX_COUNT);

   logic   start_press;
   logic   clear_press;
   state_t st;
   state_t st_nxt;
   logic   clr_nxt;

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_start),
      .press (start_press)
   );

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_clear),
      .press (clear_press)
   );

   // State register plus registered run level and clear pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         st          <= IDLE;
         start_watch <= 1'b0;
         clear_watch <= 1'b0;
      end else begin
         st          <= st_nxt;
         start_watch <= (st_nxt == RUNNING);
         clear_watch <= clr_nxt;
      end
   end

   // Next state: clear beats start outside RUNNING; in RUNNING the limit beats start
   // and clear is ignored so a live count cannot be wiped.
   always_comb begin
      st_nxt  = st;
      clr_nxt = 1'b0;
      case (st)
         IDLE: begin
            if (clear_press) begin
               clr_nxt = 1'b1;
            end else if (start_press) begin
               st_nxt = RUNNING;
            end
         end
         RUNNING: begin
            if (elapsed_time >= MAX_CMP) begin
               st_nxt = DONE;
            end else if (start_press) begin
               st_nxt = PAUSED;
            end
         end
         PAUSED: begin
            if (clear_press) begin
               st_nxt  = IDLE;
               clr_nxt = 1'b1;
            end else if (start_press) begin
               st_nxt = RUNNING;
            end
         end
         DONE: begin
            if (clear_press) begin
               st_nxt  = IDLE;
               clr_nxt = 1'b1;
            end
         end
         default: begin
            st_nxt = IDLE;
         end
      endcase
   end

   assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and scripted bench for stopwatch_ctrl against a window-based reference model.
// Checks state/start_watch/clear_watch every cycle, plus explicit timing points.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_stopwatch_ctrl;

   localparam int D    = 4;
   localparam int MAXC = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_start = 1'b0;
   logic        btn_clear = 1'b0;
   logic [13:0] elapsed_time = '0;
   logic        start_watch;
   logic        clear_watch;
   logic [1:0]  state;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   int m_st;
   bit m_sw, m_cw;
   bit m_ls, m_lc;   // debounced levels
   bit m_ps, m_pc;   // press seen by the FSM on the next edge
   bit m_hs[$];
   bit m_hc[$];

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .MAX_COUNT(MAXC)) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_start    (btn_start),
      .btn_clear    (btn_clear),
      .elapsed_time (elapsed_time),
      .start_watch  (start_watch),
      .clear_watch  (clear_watch),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // True when the samples taken 2..D+1 edges ago (what the synchronizer presents over
   // the last D edges) all equal v.
   function automatic bit window_all(input bit q[$], input bit v);
      int n = q.size();
      for (int k = 2; k <= D + 1; k++)
         if (q[n-1-k] != v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input bit s, input bit c, input bit r, input int e);
      if (r) begin
         m_st = 0; m_sw = 0; m_cw = 0;
         m_ls = 0; m_lc = 0; m_ps = 0; m_pc = 0;
         m_hs = {}; m_hc = {};
         for (int k = 0; k < D + 2; k++) begin
            m_hs.push_back(1'b0);
            m_hc.push_back(1'b0);
         end
      end else begin
         m_cw = 0;
         case (m_st)
            0: if (m_pc) m_cw = 1; else if (m_ps) m_st = 1;
            1: if (e >= MAXC) m_st = 3; else if (m_ps) m_st = 2;
            2: if (m_pc) begin m_st = 0; m_cw = 1; end else if (m_ps) m_st = 1;
            default: if (m_pc) begin m_st = 0; m_cw = 1; end
         endcase
         m_sw = (m_st == 1);
         m_hs.push_back(s);
         m_hc.push_back(c);
         m_ps = 0;
         if (window_all(m_hs, !m_ls)) begin m_ls = !m_ls; m_ps = m_ls; end
         m_pc = 0;
         if (window_all(m_hc, !m_lc)) begin m_lc = !m_lc; m_pc = m_lc; end
         if (m_hs.size() > D + 3) void'(m_hs.pop_front());
         if (m_hc.size() > D + 3) void'(m_hc.pop_front());
      end
   endtask

   task automatic step(input bit s, input bit c, input bit r, input int e);
      btn_start    = s;
      btn_clear    = c;
      reset        = r;
      elapsed_time = 14'(e);
      @(posedge clk);
      #1;
      model_edge(s, c, r, e);
      chk("state", int'(state), m_st);
      chk("start_watch", int'(start_watch), int'(m_sw));
      chk("clear_watch", int'(clear_watch), int'(m_cw));
   endtask

   task automatic hold(input bit s, input bit c, input int e, input int n);
      for (int k = 0; k < n; k++) step(s, c, 1'b0, e);
   endtask

   task automatic press(input bit s, input bit c, input int e);
      hold(s, c, e, 8);
      hold(1'b0, 1'b0, e, 8);
   endtask

   initial begin
      int ds, dc, e, rv;
      bit rs, rc, rr;

      // reset
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 0);
      chk("reset_state", int'(state), 0);
      chk("reset_start_watch", int'(start_watch), 0);
      chk("reset_clear_watch", int'(clear_watch), 0);

      // bounce shorter than the stability window
      for (int k = 0; k < 20; k++) step(((k / 2) % 2) == 0, 1'b0, 1'b0, 0);
      hold(1'b0, 1'b0, 0, 10);
      chk("bounce_start_watch", int'(start_watch), 0);
      chk("bounce_state", int'(state), 0);

      // clean start press: pulse after edge 6, RUNNING at edge 7
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 1'b0, 0);
         if (k == 6) chk("clean_edge6_state", int'(state), 0);
         if (k == 7) begin
            chk("clean_edge7_state", int'(state), 1);
            chk("clean_edge7_start_watch", int'(start_watch), 1);
         end
      end
      hold(1'b0, 1'b0, 0, 8);

      // pause, clear, clear-while-running
      press(1'b1, 1'b0, 5);
      chk("pause_state", int'(state), 2);
      press(1'b0, 1'b1, 5);
      chk("clear_state", int'(state), 0);
      press(1'b1, 1'b0, 5);
      press(1'b0, 1'b1, 5);
      chk("clear_running_state", int'(state), 1);

      // auto-stop, start ignored in DONE, clear exits
      hold(1'b0, 1'b0, MAXC, 2);
      chk("autostop_state", int'(state), 3);
      press(1'b1, 1'b0, MAXC);
      chk("done_start_state", int'(state), 3);
      press(1'b0, 1'b1, MAXC);
      chk("done_clear_state", int'(state), 0);

      // simultaneous presses in PAUSED and RUNNING
      press(1'b1, 1'b0, 3);
      press(1'b1, 1'b0, 3);
      press(1'b1, 1'b1, 3);
      chk("simul_paused_state", int'(state), 0);
      press(1'b1, 1'b0, 3);
      press(1'b1, 1'b1, 3);
      chk("simul_running_state", int'(state), 2);

      // reset two cycles into a held press
      hold(1'b1, 1'b0, 0, 2);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 0);
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 1'b0, 0);
         if (k == 6) chk("rst_mid_edge6_state", int'(state), 0);
         if (k == 7) chk("rst_mid_edge7_state", int'(state), 1);
      end
      hold(1'b0, 1'b0, 0, 8);

      // randomized traffic
      ds = 0; dc = 0; rs = 0; rc = 0;
      for (int i = 0; i < 3000; i++) begin
         if (ds == 0) begin rs = !rs; ds = $urandom_range(1, 14); end
         ds--;
         if (dc == 0) begin rc = !rc; dc = rc ? $urandom_range(1, 10) : $urandom_range(1, 40); end
         dc--;
         rv = $urandom_range(0, 99);
         if (rv < 85)      e = $urandom_range(0, MAXC - 1);
         else if (rv < 92) e = MAXC;
         else if (rv < 96) e = MAXC - 1;
         else              e = $urandom_range(MAXC + 1, 16383);
         rr = ($urandom_range(0, 499) == 0);
         step(rs, rc, rr, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
